fifo_controller: RTL
====================

// Module: fifo_controller
// PURPOSE
//  Moore FSM that sequences the FIFO datapath: write buffer, FIFO RAM, pointer, read buffer and status register.
//  Accepts write/read requests and arbitrates simultaneous requests round-robin.
//  Each accepted request expands into a fixed micro-sequence of datapath strobes.
//  Refuses requests the full/empty status forbids.
// PARAMETERS
//  INIT_CYCLES  2  cycles the Clear* strobes are held after reset or soft clear (>=1)
//  CNT_W        2  width of the init counter; must satisfy 2**CNT_W > INIT_CYCLES
// PORTS
//  clk            in   1  global clock, rising edge
//  Clear_n        in   1  reset, asynchronous, active-low
//  wr_req         in   1  write request, level; sampled in IDLE only
//  rd_req         in   1  read request, level; sampled in IDLE only
//  soft_clr       in   1  synchronous re-initialise request; sampled in IDLE only
//  full           in   1  status register full flag
//  empty          in   1  status register empty flag
//  ClearFIFO      out  1  RAM clear
//  ClearWriteBuff out  1  write buffer clear
//  ClearReadBuff  out  1  read buffer clear
//  ClearPoint     out  1  pointer clear
//  ClearStaReg    out  1  status register clear
//  LoadWriteBuff  out  1  write buffer load
//  LoadReadBuff   out  1  read buffer load
//  ChipEnable     out  1  RAM enable
//  OutEnable      out  1  RAM output enable
//  Write          out  1  RAM direction: 1=write, 0=read
//  sel            out  1  pointer direction: 1=increment (write), 0=decrement (read)
//  EnableP        out  1  pointer step enable
//  wr_ack         out  1  1-cycle pulse: write sequence finished
//  rd_ack         out  1  1-cycle pulse: read data valid on DataOut from next cycle
//  wr_err         out  1  1-cycle pulse: write refused, FIFO full
//  rd_err         out  1  1-cycle pulse: read refused, FIFO empty
//  busy           out  1  high in every state except IDLE
// BEHAVIOUR
//  - States: INIT, IDLE, W_LOAD, W_MEM, W_PTR, R_PTR, R_MEM, R_LOAD, SETTLE.
//  - State, init counter and round-robin flag last_wr are registers; async reset -> INIT, counter=0, last_wr=0.
//  - Outputs are pure decodes of state, plus IDLE error decode; no output depends combinationally on wr_req/rd_req except *_err.
//  - INIT: all five Clear* = 1, busy = 1, all other outputs 0.
//    - This is the output value while Clear_n is low.
//    - Stays INIT_CYCLES cycles after Clear_n rises (counter), then -> IDLE.
//  - IDLE: all strobes 0. Evaluation order:
//    - soft_clr=1 -> INIT; wr_req/rd_req ignored that cycle.
//    - Write candidate = wr_req & ~full; read candidate = rd_req & ~empty.
//    - Both candidates -> serve read if last_wr=1, else write.
//    - Single candidate -> serve it.
//    - Write start -> W_LOAD, last_wr<=1. Read start -> R_PTR, last_wr<=0.
//    - wr_err = wr_req & full; rd_err = rd_req & empty.
//      - Asserted in IDLE regardless of whether the other request is served; stays IDLE if nothing served.
//  - Write sequence (4 cycles, then IDLE):
//    - W_LOAD: LoadWriteBuff=1.
//    - W_MEM: ChipEnable=1, Write=1.
//    - W_PTR: EnableP=1, sel=1, wr_ack=1.
//    - SETTLE.
//  - Read sequence (4 cycles, then IDLE):
//    - R_PTR: EnableP=1, sel=0.
//    - R_MEM: ChipEnable=1, OutEnable=1, Write=0.
//    - R_LOAD: ChipEnable=1, OutEnable=1, LoadReadBuff=1, rd_ack=1.
//    - SETTLE.
//  - SETTLE: all strobes 0; one cycle so the status register reflects the new pointer before IDLE samples full/empty.
//  - Sequences are not interruptible by requests or soft_clr. Only Clear_n aborts, asynchronously, to INIT mid-sequence.
//  - Minimum request-to-ack latency: write 3 cycles (W_LOAD..W_PTR); read 3 cycles.
//  - Back-to-back throughput: one operation per 5 cycles (IDLE + 4).
//  - Unused/illegal state encodings -> INIT on next clock.
// TESTING
//  1. Clear_n low 3 cycles, release -> Clear* high exactly 2 more cycles, then IDLE with busy=0, all strobes 0.
//  2. Empty FIFO, wr_req=1 one cycle:
//     - strobe order LoadWriteBuff, ChipEnable+Write, EnableP+sel=1.
//     - wr_ack in 3rd cycle; busy high 4 cycles.
//  3. empty=1, rd_req=1 -> rd_err single pulse in IDLE, no strobes, state stays IDLE.
//  4. full=0, empty=0, wr_req=rd_req=1 held 20 cycles -> ops alternate W,R,W,R: 4 acks, 2 wr_ack, 2 rd_ack.
//  5. full=1, wr_req=rd_req=1 -> wr_err pulse and read sequence starts in the same IDLE cycle.
//  6. Clear_n pulsed low during W_MEM -> outputs go to INIT values immediately (async), no wr_ack.

Source files
------------

// File: rtl/fifo_controller_if.sv
// ============================================================================
// Module      : fifo_controller_if
// Description : Request/status inputs and datapath strobes of the FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_controller_if;
  logic wr_req;
  logic rd_req;
  logic soft_clr;
  logic full;
  logic empty;
  logic ClearFIFO;
  logic ClearWriteBuff;
  logic ClearReadBuff;
  logic ClearPoint;
  logic ClearStaReg;
  logic LoadWriteBuff;
  logic LoadReadBuff;
  logic ChipEnable;
  logic OutEnable;
  logic Write;
  logic sel;
  logic EnableP;
  logic wr_ack;
  logic rd_ack;
  logic wr_err;
  logic rd_err;
  logic busy;

  modport slave (
    input  wr_req, rd_req, soft_clr, full, empty,
    output ClearFIFO, ClearWriteBuff, ClearReadBuff, ClearPoint, ClearStaReg,
    output LoadWriteBuff, LoadReadBuff, ChipEnable, OutEnable, Write, sel, EnableP,
    output wr_ack, rd_ack, wr_err, rd_err, busy
  );

  modport master (
    output wr_req, rd_req, soft_clr, full, empty,
    input  ClearFIFO, ClearWriteBuff, ClearReadBuff, ClearPoint, ClearStaReg,
    input  LoadWriteBuff, LoadReadBuff, ChipEnable, OutEnable, Write, sel, EnableP,
    input  wr_ack, rd_ack, wr_err, rd_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/fifo_controller.sv
// ============================================================================
// Module      : fifo_controller
// Description : Moore sequencer for the FIFO datapath with round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_controller #(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 2
) (
  input  logic               clk,
  input  logic               Clear_n,
  fifo_controller_if.slave   bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_IDLE   = 4'd1,
    S_W_LOAD = 4'd2,
    S_W_MEM  = 4'd3,
    S_W_PTR  = 4'd4,
    S_R_PTR  = 4'd5,
    S_R_MEM  = 4'd6,
    S_R_LOAD = 4'd7,
    S_SETTLE = 4'd8
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_wr_q, last_wr_d;

  logic               w_wr_cand, w_rd_cand, w_serve_wr, w_serve_rd;

  // On a tie the direction not served last time wins.
  assign w_wr_cand  = bus.wr_req & ~bus.full;
  assign w_rd_cand  = bus.rd_req & ~bus.empty;
  assign w_serve_wr = w_wr_cand & (~w_rd_cand | ~last_wr_q);
  assign w_serve_rd = w_rd_cand & (~w_wr_cand |  last_wr_q);

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    last_wr_d = last_wr_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) state_d = S_IDLE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      S_IDLE: begin
        if (bus.soft_clr) begin
          state_d = S_INIT;
        end else if (w_serve_wr) begin
          state_d   = S_W_LOAD;
          last_wr_d = 1'b1;
        end else if (w_serve_rd) begin
          state_d   = S_R_PTR;
          last_wr_d = 1'b0;
        end
      end
      S_W_LOAD: state_d = S_W_MEM;
      S_W_MEM:  state_d = S_W_PTR;
      S_W_PTR:  state_d = S_SETTLE;
      S_R_PTR:  state_d = S_R_MEM;
      S_R_MEM:  state_d = S_R_LOAD;
      S_R_LOAD: state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.ClearFIFO      = 1'b0;
    bus.ClearWriteBuff = 1'b0;
    bus.ClearReadBuff  = 1'b0;
    bus.ClearPoint     = 1'b0;
    bus.ClearStaReg    = 1'b0;
    bus.LoadWriteBuff  = 1'b0;
    bus.LoadReadBuff   = 1'b0;
    bus.ChipEnable     = 1'b0;
    bus.OutEnable      = 1'b0;
    bus.Write          = 1'b0;
    bus.sel            = 1'b0;
    bus.EnableP        = 1'b0;
    bus.wr_ack         = 1'b0;
    bus.rd_ack         = 1'b0;
    bus.wr_err         = 1'b0;
    bus.rd_err         = 1'b0;
    bus.busy           = (state_q != S_IDLE);
    case (state_q)
      S_INIT: begin
        bus.ClearFIFO      = 1'b1;
        bus.ClearWriteBuff = 1'b1;
        bus.ClearReadBuff  = 1'b1;
        bus.ClearPoint     = 1'b1;
        bus.ClearStaReg    = 1'b1;
      end
      S_IDLE: begin
        // A soft clear swallows the requests of that cycle, errors included.
        bus.wr_err = ~bus.soft_clr & bus.wr_req & bus.full;
        bus.rd_err = ~bus.soft_clr & bus.rd_req & bus.empty;
      end
      S_W_LOAD: bus.LoadWriteBuff = 1'b1;
      S_W_MEM: begin
        bus.ChipEnable = 1'b1;
        bus.Write      = 1'b1;
      end
      S_W_PTR: begin
        bus.EnableP = 1'b1;
        bus.sel     = 1'b1;
        bus.wr_ack  = 1'b1;
      end
      S_R_PTR: bus.EnableP = 1'b1;
      S_R_MEM: begin
        bus.ChipEnable = 1'b1;
        bus.OutEnable  = 1'b1;
      end
      S_R_LOAD: begin
        bus.ChipEnable   = 1'b1;
        bus.OutEnable    = 1'b1;
        bus.LoadReadBuff = 1'b1;
        bus.rd_ack       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
